// File: rtl/axi_bram_pkg.sv
// axi_bram_pkg: response codes and controller states shared by the AXI4-Lite BRAM controller.
package axi_bram_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;
  typedef enum logic [2:0] {
    IDLE,
    WR_RESP,
    RD_WAIT,
    RD_CAP,
    RD_RESP
  } ctrl_state_t;
endpackage

// File: rtl/axi_lite_bram_ctrl.sv
// axi_lite_bram_ctrl: AXI4-Lite slave driving a native single-port BRAM, one transaction at a time.
module axi_lite_bram_ctrl
  import axi_bram_pkg::*;
#(
  parameter int MEM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH = 11,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int READ_ONLY       = 0
) (
  input  logic                        clka,
  input  logic                        rsta,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [MEM_DATA_WIDTH-1:0]   s_wdata,
  input  logic [MEM_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [MEM_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic [BRAM_ADDR_WIDTH-1:0]  addra,
  output logic                        ena,
  output logic [MEM_DATA_WIDTH/8-1:0] wea,
  output logic [MEM_DATA_WIDTH-1:0]   dina,
  input  logic [MEM_DATA_WIDTH-1:0]   douta
);
  ctrl_state_t state, state_d;
  logic last_wr, idle_free, wr_elig, grant_wr, grant_rd, hs_wr, hs_rd;
  logic addr_unused;
  assign addr_unused = ^{s_awaddr[AXI_ADDR_WIDTH-1:BRAM_ADDR_WIDTH], s_araddr[AXI_ADDR_WIDTH-1:BRAM_ADDR_WIDTH]};
  // Grants are only issued while no ready is pending; the handshake lands in the following cycle.
  always_comb begin
    idle_free = state == IDLE && !s_awready && !s_arready;
    wr_elig   = s_awvalid && s_wvalid;
    grant_wr  = idle_free && wr_elig && (!s_arvalid || !last_wr);
    grant_rd  = idle_free && s_arvalid && (!wr_elig || last_wr);
    hs_wr     = state == IDLE && s_awready && wr_elig;
    hs_rd     = state == IDLE && s_arready && s_arvalid;
    state_d   = state;
    case (state)
      IDLE:    state_d = hs_wr ? WR_RESP : hs_rd ? RD_WAIT : IDLE;
      WR_RESP: state_d = s_bready ? IDLE : WR_RESP;
      RD_WAIT: state_d = RD_CAP;
      RD_CAP:  state_d = RD_RESP;
      RD_RESP: state_d = s_rready ? IDLE : RD_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clka) begin
    if (rsta) begin
      state <= IDLE;
      last_wr <= 1'b1;
      {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, ena} <= '0;
      {s_bresp, s_rresp} <= '0;
      addra <= '0;
      wea <= '0;
      dina <= '0;
      s_rdata <= '0;
    end else begin
      state <= state_d;
      s_awready <= grant_wr;
      s_wready <= grant_wr;
      s_arready <= grant_rd;
      if (grant_wr || grant_rd) last_wr <= grant_wr;
      ena <= hs_wr || hs_rd;
      wea <= hs_wr && READ_ONLY == 0 ? s_wstrb : '0;
      if (hs_wr) begin
        addra <= s_awaddr[BRAM_ADDR_WIDTH-1:0];
        dina <= s_wdata;
        s_bvalid <= 1'b1;
        s_bresp <= READ_ONLY != 0 ? RESP_SLVERR : RESP_OKAY;
      end
      if (hs_rd) addra <= s_araddr[BRAM_ADDR_WIDTH-1:0];
      if (state == WR_RESP && s_bready) s_bvalid <= 1'b0;
      if (state == RD_CAP) begin
        s_rdata <= douta;
        s_rvalid <= 1'b1;
        s_rresp <= RESP_OKAY;
      end
      if (state == RD_RESP && s_rready) s_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// tb_axi_lite_bram_ctrl: read-write and read-only controllers driven in lockstep against BRAM models and a word-array reference.
module tb_axi_lite_bram_ctrl;
  logic clka = 0;
  always #5 clka = ~clka;
  logic rsta, awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0] wstrb;
  logic awready [2], wready [2], arready [2], bvalid [2], rvalid [2], ena [2];
  logic [1:0] bresp [2], rresp [2];
  logic [31:0] rdata [2], dina [2], douta [2];
  logic [10:0] addra [2];
  logic [3:0] wea [2];
  logic [31:0] mem0 [512], mem1 [512], ref_mem [512];
  bit loaded = 0;
  int total = 0, bad = 0;

  axi_lite_bram_ctrl #(.READ_ONLY(0)) u_rw (
    .clka(clka), .rsta(rsta),
    .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[0]),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready[0]),
    .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[0]),
    .s_rdata(rdata[0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]), .s_rready(rready),
    .addra(addra[0]), .ena(ena[0]), .wea(wea[0]), .dina(dina[0]), .douta(douta[0])
  );
  axi_lite_bram_ctrl #(.READ_ONLY(1)) u_ro (
    .clka(clka), .rsta(rsta),
    .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[1]),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready[1]),
    .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[1]),
    .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]), .s_rready(rready),
    .addra(addra[1]), .ena(ena[1]), .wea(wea[1]), .dina(dina[1]), .douta(douta[1])
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Behavioural BRAMs: douta follows the cycle after ena and holds otherwise.
  always @(posedge clka) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= init_word(i);
        mem1[i] <= init_word(i);
      end
      loaded <= 1'b1;
    end else begin
      if (ena[0]) begin
        for (int b = 0; b < 4; b++) if (wea[0][b]) mem0[addra[0][10:2]][8*b+:8] <= dina[0][8*b+:8];
        douta[0] <= mem0[addra[0][10:2]];
      end
      if (ena[1]) begin
        for (int b = 0; b < 4; b++) if (wea[1][b]) mem1[addra[1][10:2]][8*b+:8] <= dina[1][8*b+:8];
        douta[1] <= mem1[addra[1][10:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clka);
    #1;
  endtask

  task automatic zero_chk(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk(tag, {awready[i], wready[i], arready[i], bvalid[i], rvalid[i], ena[i], wea[i], addra[i], bresp[i], rresp[i]}, 64'd0);
      chk(tag, {dina[i], rdata[i]}, 64'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int bp);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    while (!awready[0] && n < 20) begin tick(); n++; end
    chk("aw_hs", {awready[0], wready[0], arready[0], awready[1], wready[1]}, 64'b11011);
    tick();
    awvalid = 0; wvalid = 0;
    chk("wr_bram_rw", {ena[0], wea[0], addra[0], dina[0]}, {1'b1, s, a[10:0], d});
    chk("wr_bram_ro", {ena[1], wea[1]}, {1'b1, 4'h0});
    chk("wr_b", {bvalid[0], bresp[0], bvalid[1], bresp[1]}, {1'b1, 2'b00, 1'b1, 2'b10});
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[10:2]][8*b+:8] = d[8*b+:8];
    repeat (bp) begin
      tick();
      chk("wr_bp", {bvalid[0], bresp[0], bvalid[1], bresp[1], ena[0], wea[0], awready[0], arready[0]},
          {1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 4'h0, 1'b0, 1'b0});
    end
    bready = 1;
    tick();
    bready = 0;
    chk("wr_done", {bvalid[0], bvalid[1], ena[0], ena[1]}, 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int bp);
    int n = 0;
    logic [31:0] exp_rw, exp_ro;
    araddr = a; arvalid = 1;
    while (!arready[0] && n < 20) begin tick(); n++; end
    chk("ar_hs", {arready[0], awready[0], arready[1]}, 64'b101);
    tick();
    arvalid = 0;
    chk("rd_bram", {ena[0], wea[0], addra[0], ena[1], wea[1], rvalid[0]}, {1'b1, 4'h0, a[10:0], 1'b1, 4'h0, 1'b0});
    tick();
    chk("rd_cap", {ena[0], rvalid[0], rvalid[1]}, 64'd0);
    tick();
    exp_rw = ref_mem[a[10:2]];
    exp_ro = init_word(int'(a[10:2]));
    chk("rd_r_rw", {rvalid[0], rresp[0], rdata[0]}, {1'b1, 2'b00, exp_rw});
    chk("rd_r_ro", {rvalid[1], rresp[1], rdata[1]}, {1'b1, 2'b00, exp_ro});
    repeat (bp) begin
      tick();
      chk("rd_bp", {rvalid[0], rresp[0], rdata[0], arready[0], awready[0]}, {1'b1, 2'b00, exp_rw, 1'b0, 1'b0});
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rd_done", {rvalid[0], rvalid[1]}, 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rsta = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    repeat (3) tick();
    zero_chk("reset");
    rsta = 0;
    tick();
    // Tie right after reset: read first with old data, then a fresh tie grants the pending write.
    awaddr = 32'h40; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    do_read(32'h40, 0);
    chk("tie_old", rdata[0], init_word(16));
    araddr = 32'h40; arvalid = 1;
    do_write(32'h40, 32'hCAFE_F00D, 4'hF, 0);
    do_read(32'h40, 0);
    chk("tie_new", rdata[0], 32'hCAFE_F00D);
    do_write(32'h100, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(32'h100, 0);
    chk("wr_rd", rdata[0], 32'hDEAD_BEEF);
    do_write(32'h20, 32'h1122_3344, 4'hF, 1);
    do_write(32'h20, 32'hAABB_CCDD, 4'b0101, 0);
    do_read(32'h20, 0);
    chk("partial", rdata[0], 32'h11BB_33DD);
    do_write(32'h22, 32'hFFFF_FFFF, 4'h0, 0);
    do_read(32'h23, 0);
    chk("strb0", rdata[0], 32'h11BB_33DD);
    do_write(32'h104, 32'h0BAD_CAFE, 4'hF, 10);
    do_read(32'h104, 10);
    do_write(32'h0, 32'h1234_5678, 4'hF, 0);
    do_read(32'h0, 0);
    chk("ro_keep", rdata[1], init_word(0));
    // Reset while the BRAM is sampling a read address.
    araddr = 32'h8; arvalid = 1; n = 0;
    while (!arready[0] && n < 20) begin tick(); n++; end
    chk("mid_ar", arready[0], 1'b1);
    tick();
    arvalid = 0; rsta = 1;
    tick();
    zero_chk("mid_rst");
    rsta = 0;
    repeat (6) begin
      tick();
      chk("no_rvalid", {rvalid[0], rvalid[1]}, 64'd0);
    end
    do_read(32'h8, 0);
    do_read(32'h0000_0808, 0);
    chk("alias", rdata[0], ref_mem[2]);
    for (int k = 0; k < 40; k++) begin
      a = ($urandom & 32'hFFFF_F803) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else do_read(a, $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
